// File: rtl/fetch_stage_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_stage_pkg;

  localparam int PC_W = 32;
  localparam logic [PC_W-1:0] NOP_INSTR = 32'h0000_0000;

  typedef enum logic [1:0] {
    FETCH   = 2'd0,
    HOLD    = 2'd1,
    DISCARD = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/if_id_reg.sv
// Pipeline register carrying {pc, instruction, valid} between two stages.
// flush beats load; with neither asserted the contents hold.
module if_id_reg
  import fetch_stage_pkg::*;
#(
  parameter int W = PC_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         flush,
  input  logic [W-1:0] d_pc,
  input  logic [W-1:0] d_instr,
  input  logic         d_valid,
  output logic [W-1:0] q_pc,
  output logic [W-1:0] q_instr,
  output logic         q_valid
);

  // Load, flush to a bubble, or hold the current entry.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      q_pc    <= '0;
      q_instr <= NOP_INSTR;
      q_valid <= 1'b0;
    end else if (load) begin
      q_pc    <= d_pc;
      q_instr <= d_instr;
      q_valid <= d_valid;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage with IF/ID register.
// Optional performance counters are built when FETCH_PERF_EN is defined.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] PC_STEP  = 32'd4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            freeze,
  input  logic            branch_taken,
  input  logic [PC_W-1:0] branch_addr,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [PC_W-1:0] imem_rdata,
  output logic [PC_W-1:0] pc_out,
  output logic [PC_W-1:0] instruction,
  output logic            valid
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]     perf_fetch_cnt,
  output logic [31:0]     perf_flush_cnt,
  output logic [31:0]     perf_wait_cnt
`endif
);

  fetch_state_e    state;
  logic [PC_W-1:0] req_addr;
  logic [PC_W-1:0] hold_buf;
  logic [PC_W-1:0] redir;
  // Low only in the cycle after reset, so a late ack is never consumed.
  logic            req_en;

  logic            acc;
  logic            word_avail;
  logic            ld;
  logic [PC_W-1:0] d_pc;
  logic [PC_W-1:0] d_instr;
  logic [PC_W-1:0] next_pc;

  assign imem_req  = req_en && (state != HOLD);
  assign imem_addr = req_addr;
  assign acc       = imem_req && imem_ack;
  assign next_pc   = req_addr + PC_STEP;

  // IF/ID input selection: a word is available either from memory this
  // cycle or from the hold buffer; otherwise a bubble is loaded.
  always_comb begin
    word_avail = (state == HOLD) || ((state == FETCH) && acc);
    ld         = !freeze;
    d_pc       = '0;
    d_instr    = NOP_INSTR;
    if (word_avail) begin
      d_pc    = next_pc;
      d_instr = (state == HOLD) ? hold_buf : imem_rdata;
    end
  end

  if_id_reg #(.W(PC_W)) u_if_id (
    .clk     (clk),
    .rst     (rst),
    .load    (ld),
    .flush   (branch_taken),
    .d_pc    (d_pc),
    .d_instr (d_instr),
    .d_valid (word_avail),
    .q_pc    (pc_out),
    .q_instr (instruction),
    .q_valid (valid)
  );

  // Fetch FSM: PC advance, freeze buffering and branch redirect.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= FETCH;
      req_addr <= RESET_PC;
      hold_buf <= '0;
      redir    <= '0;
      req_en   <= 1'b0;
    end else begin
      req_en <= 1'b1;
      case (state)
        FETCH: begin
          if (branch_taken) begin
            // No outstanding request (acked or not yet issued): redirect now.
            if (acc || !req_en) begin
              req_addr <= branch_addr;
            end else begin
              redir <= branch_addr;
              state <= DISCARD;
            end
          end else if (acc) begin
            if (freeze) begin
              hold_buf <= imem_rdata;
              state    <= HOLD;
            end else begin
              req_addr <= next_pc;
            end
          end
        end
        HOLD: begin
          if (branch_taken) begin
            hold_buf <= '0;
            req_addr <= branch_addr;
            state    <= FETCH;
          end else if (!freeze) begin
            req_addr <= next_pc;
            state    <= FETCH;
          end
        end
        DISCARD: begin
          // Address stays put until the stale response returns.
          if (acc) begin
            req_addr <= branch_taken ? branch_addr : redir;
            state    <= FETCH;
          end else if (branch_taken) begin
            redir <= branch_addr;
          end
        end
        default: state <= FETCH;
      endcase
    end
  end

`ifdef FETCH_PERF_EN
  // Delivered instructions, flush cycles and memory wait cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_fetch_cnt <= '0;
      perf_flush_cnt <= '0;
      perf_wait_cnt  <= '0;
    end else begin
      if (ld && word_avail && !branch_taken) perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
      if (branch_taken)                      perf_flush_cnt <= perf_flush_cnt + 32'd1;
      if (imem_req && !imem_ack)             perf_wait_cnt  <= perf_wait_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst, freeze, branch_taken, imem_ack;
  logic [31:0] branch_addr, imem_rdata;
  logic        imem_req, valid;
  logic [31:0] imem_addr, pc_out, instruction;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetch_cnt, perf_flush_cnt, perf_wait_cnt;
`endif

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  exp_t sb[$];
  int   tests_run = 0;
  int   failures  = 0;
  int   delivered = 0;

  always #5 clk = ~clk;

  fetch_stage dut (
    .clk          (clk),
    .rst          (rst),
    .freeze       (freeze),
    .branch_taken (branch_taken),
    .branch_addr  (branch_addr),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ack     (imem_ack),
    .imem_rdata   (imem_rdata),
    .pc_out       (pc_out),
    .instruction  (instruction),
    .valid        (valid)
`ifdef FETCH_PERF_EN
    ,
    .perf_fetch_cnt (perf_fetch_cnt),
    .perf_flush_cnt (perf_flush_cnt),
    .perf_wait_cnt  (perf_wait_cnt)
`endif
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    freeze = 0; branch_taken = 0; branch_addr = '0; imem_ack = 0; imem_rdata = '0;
  endtask

  // Reset and release; returns with the first request (RESET_PC) up.
  task automatic apply_reset();
    idle_inputs();
    rst = 1;
    step(); step();
    rst = 0;
    step();
    sb.delete();
    delivered = 0;
  endtask

  // Memory model with fixed ack latency; scoreboards every accepted word.
  task automatic run(input int n, input int lat, input int gap);
    int          cnt = 0;
    int          bub = 0;
    bit          seen = 0;
    logic [31:0] a_hold = '0;
    exp_t        e;
    for (int i = 0; i <= n; i++) begin
      if (valid) begin
        tests_run++;
        if (sb.size() == 0) begin
          failures++;
          $display("FAIL sb_extra: got pc=%h instr=%h, none expected", pc_out, instruction);
        end else begin
          e = sb.pop_front();
          if (pc_out !== e.pc || instruction !== e.instr) begin
            failures++;
            $display("FAIL sb_word: got pc=%h instr=%h, want pc=%h instr=%h",
                     pc_out, instruction, e.pc, e.instr);
          end
        end
        if (seen && gap >= 0) begin
          tests_run++;
          if (bub !== gap) begin
            failures++;
            $display("FAIL bubble_gap: got %0d, want %0d", bub, gap);
          end
        end
        delivered++;
        seen = 1;
        bub  = 0;
      end else begin
        bub++;
        tests_run++;
        if (instruction !== 32'h0) begin
          failures++;
          $display("FAIL bubble_instr: got %h, want 0", instruction);
        end
      end
      if (i == n) break;
      imem_ack = 0; imem_rdata = '0;
      if (imem_req) begin
        if (cnt > 0) begin
          tests_run++;
          if (imem_addr !== a_hold) begin
            failures++;
            $display("FAIL addr_stable: got %h, want %h", imem_addr, a_hold);
          end
        end
        a_hold = imem_addr;
        if (cnt == lat) begin
          imem_ack   = 1;
          imem_rdata = {8'hA5, imem_addr[23:0]};
          e.pc    = imem_addr + 32'd4;
          e.instr = imem_rdata;
          sb.push_back(e);
          cnt = 0;
        end else begin
          cnt++;
        end
      end
      step();
    end
    imem_ack = 0;
    tests_run++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL sb_leftover: got %0d pending, want 0", sb.size());
    end
    sb.delete();
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1;
    step(); step();
    tests_run++;
    if (imem_req !== 1'b0 || valid !== 1'b0 || pc_out !== 32'h0 || instruction !== 32'h0) begin
      failures++;
      $display("FAIL reset_state: req=%b valid=%b pc=%h instr=%h, want all 0",
               imem_req, valid, pc_out, instruction);
    end
`ifdef FETCH_PERF_EN
    tests_run++;
    if (perf_fetch_cnt !== 0 || perf_flush_cnt !== 0 || perf_wait_cnt !== 0) begin
      failures++;
      $display("FAIL reset_perf: got %0d/%0d/%0d, want 0", perf_fetch_cnt, perf_flush_cnt, perf_wait_cnt);
    end
`endif
    rst = 0;
    step();
    tests_run++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
      failures++;
      $display("FAIL reset_first_req: req=%b addr=%h, want 1 / 0", imem_req, imem_addr);
    end
  endtask

  task automatic test_stream();
    apply_reset();
    run(10, 0, 0);
    tests_run++;
    if (delivered !== 10) begin
      failures++;
      $display("FAIL stream_count: got %0d, want 10", delivered);
    end
`ifdef FETCH_PERF_EN
    tests_run++;
    if (perf_fetch_cnt !== 32'd10) begin
      failures++;
      $display("FAIL perf_fetch: got %0d, want 10", perf_fetch_cnt);
    end
`endif
  endtask

  task automatic test_latency();
    apply_reset();
    run(20, 3, 3);
  endtask

  task automatic test_freeze();
    apply_reset();
    imem_ack = 1; imem_rdata = 32'h1111_1111;
    step();
    imem_rdata = 32'hE3A0_1005; freeze = 1;
    step();
    imem_ack = 0; imem_rdata = '0;
    for (int k = 0; k < 4; k++) begin
      tests_run++;
      if (imem_req !== 1'b0 || valid !== 1'b1 || pc_out !== 32'h4 || instruction !== 32'h1111_1111) begin
        failures++;
        $display("FAIL freeze_hold: req=%b valid=%b pc=%h instr=%h, want 0/1/4/11111111",
                 imem_req, valid, pc_out, instruction);
      end
      if (k < 3) step();
    end
    freeze = 0;
    step();
    tests_run++;
    if (valid !== 1'b1 || pc_out !== 32'h8 || instruction !== 32'hE3A0_1005 ||
        imem_req !== 1'b1 || imem_addr !== 32'h8) begin
      failures++;
      $display("FAIL freeze_release: valid=%b pc=%h instr=%h req=%b addr=%h, want 1/8/e3a01005/1/8",
               valid, pc_out, instruction, imem_req, imem_addr);
    end
  endtask

  task automatic test_branch();
    apply_reset();
    imem_ack = 1;
    for (int k = 0; k < 8; k++) begin
      imem_rdata = {8'hA5, imem_addr[23:0]};
      step();
    end
    imem_ack = 0; imem_rdata = '0;
    branch_taken = 1; branch_addr = 32'h100;
    step();
    branch_taken = 0;
    tests_run++;
    if (valid !== 1'b0 || instruction !== 32'h0 || imem_req !== 1'b1 || imem_addr !== 32'h20) begin
      failures++;
      $display("FAIL branch_flush: valid=%b instr=%h req=%b addr=%h, want 0/0/1/20",
               valid, instruction, imem_req, imem_addr);
    end
    imem_ack = 1; imem_rdata = 32'hDEAD_BEEF;
    step();
    tests_run++;
    if (valid !== 1'b0 || instruction !== 32'h0 || imem_addr !== 32'h100) begin
      failures++;
      $display("FAIL branch_drop: valid=%b instr=%h addr=%h, want 0/0/100",
               valid, instruction, imem_addr);
    end
    imem_rdata = 32'hC0DE_0100;
    step();
    imem_ack = 0;
    tests_run++;
    if (valid !== 1'b1 || pc_out !== 32'h104 || instruction !== 32'hC0DE_0100) begin
      failures++;
      $display("FAIL branch_target: valid=%b pc=%h instr=%h, want 1/104/c0de0100",
               valid, pc_out, instruction);
    end
  endtask

  task automatic test_branch_freeze();
    apply_reset();
    imem_ack = 1; imem_rdata = 32'h2222_2222;
    step();
    freeze = 1; branch_taken = 1; branch_addr = 32'h200; imem_rdata = 32'h3333_3333;
    step();
    freeze = 0; branch_taken = 0;
    tests_run++;
    if (valid !== 1'b0 || instruction !== 32'h0 || imem_req !== 1'b1 || imem_addr !== 32'h200) begin
      failures++;
      $display("FAIL branch_freeze: valid=%b instr=%h req=%b addr=%h, want 0/0/1/200",
               valid, instruction, imem_req, imem_addr);
    end
    imem_rdata = 32'h4444_4444;
    step();
    imem_ack = 0;
    tests_run++;
    if (valid !== 1'b1 || pc_out !== 32'h204 || instruction !== 32'h4444_4444) begin
      failures++;
      $display("FAIL branch_freeze_next: valid=%b pc=%h instr=%h, want 1/204/44444444",
               valid, pc_out, instruction);
    end
  endtask

  task automatic test_wrap();
    apply_reset();
    imem_ack = 1; imem_rdata = 32'h5555_5555;
    branch_taken = 1; branch_addr = 32'hFFFF_FFFC;
    step();
    branch_taken = 0;
    tests_run++;
    if (imem_addr !== 32'hFFFF_FFFC || valid !== 1'b0) begin
      failures++;
      $display("FAIL wrap_redirect: addr=%h valid=%b, want fffffffc/0", imem_addr, valid);
    end
    imem_rdata = 32'h0000_1234;
    step();
    imem_ack = 0;
    tests_run++;
    if (valid !== 1'b1 || pc_out !== 32'h0 || instruction !== 32'h1234 || imem_addr !== 32'h0) begin
      failures++;
      $display("FAIL wrap_pc: valid=%b pc=%h instr=%h addr=%h, want 1/0/1234/0",
               valid, pc_out, instruction, imem_addr);
    end
  endtask

  task automatic test_reset_discard();
    apply_reset();
    branch_taken = 1; branch_addr = 32'h40;
    step();
    branch_taken = 0;
    tests_run++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
      failures++;
      $display("FAIL discard_enter: req=%b addr=%h, want 1/0", imem_req, imem_addr);
    end
    rst = 1; imem_ack = 1; imem_rdata = 32'hDEAD_0000;
    step();
    rst = 0;
    tests_run++;
    if (imem_req !== 1'b0 || valid !== 1'b0 || pc_out !== 32'h0 || instruction !== 32'h0) begin
      failures++;
      $display("FAIL discard_reset: req=%b valid=%b pc=%h instr=%h, want all 0",
               imem_req, valid, pc_out, instruction);
    end
`ifdef FETCH_PERF_EN
    tests_run++;
    if (perf_fetch_cnt !== 0 || perf_flush_cnt !== 0 || perf_wait_cnt !== 0) begin
      failures++;
      $display("FAIL discard_perf: got %0d/%0d/%0d, want 0", perf_fetch_cnt, perf_flush_cnt, perf_wait_cnt);
    end
`endif
    step();
    imem_ack = 0;
    tests_run++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0 || valid !== 1'b0 || instruction !== 32'h0) begin
      failures++;
      $display("FAIL late_ack: req=%b addr=%h valid=%b instr=%h, want 1/0/0/0",
               imem_req, imem_addr, valid, instruction);
    end
  endtask

  initial begin
    rst = 1;
    idle_inputs();
    test_reset();
    test_stream();
    test_latency();
    test_freeze();
    test_branch();
    test_branch_freeze();
    test_wrap();
    test_reset_discard();
    $display("[TB] %0d tests run, %0d failed", tests_run, failures);
    $finish;
  end

endmodule
